// File: rtl/sram_host_sequencer_pkg.sv
// Shared types and width helpers for the SRAM host sequencer.
package sram_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WSETUP,
    ST_WPULSE,
    ST_RESP,
    ST_RSETUP,
    ST_RPULSE,
    ST_RWAIT
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Row address width; never narrower than one bit.
  function automatic int calc_aw(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // Burst length field width (holds beats-1); never narrower than one bit.
  function automatic int calc_lw(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

  // Width of a counter running 0..n-1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_host_sequencer_if.sv
// Request/response handshake between a host and the SRAM sequencer.
interface sram_host_sequencer_if #(
  parameter int AW   = 4,
  parameter int LW   = 2,
  parameter int COLS = 8
);

  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [LW-1:0]   req_len;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid;
  logic [COLS-1:0] rsp_rdata;
  logic            rsp_error;
  logic            rsp_last;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_last
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_last
  );

endinterface

// File: rtl/sram_bit_serializer.sv
// MSB-first word serializer: each bit is presented for SHIFT_HOLD cycles,
// done is high during the final cycle of the final bit.
module sram_bit_serializer
  import sram_host_pkg::*;
#(
  parameter int COLS       = 8,
  parameter int SHIFT_HOLD = 2
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            load,
  input  logic [COLS-1:0] load_data,
  output logic            serial_out,
  output logic            done
);

  localparam int HW = cnt_w(SHIFT_HOLD);
  localparam int BW = cnt_w(COLS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SHIFT_HOLD - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(COLS - 1);

  logic [COLS-1:0] sreg_q;
  logic [HW-1:0]   hold_q;
  logic [BW-1:0]   bit_q;
  logic            active_q;

  // Shift register with per-bit hold; zeros shift in so the line idles low.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sreg_q   <= '0;
      hold_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      sreg_q   <= load_data;
      hold_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (hold_q == HOLD_LAST) begin
        hold_q <= '0;
        sreg_q <= sreg_q << 1;
        if (bit_q == BIT_LAST) begin
          bit_q    <= '0;
          active_q <= 1'b0;
        end else begin
          bit_q <= bit_q + 1'b1;
        end
      end else begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  assign serial_out = sreg_q[COLS-1];
  assign done       = active_q && (hold_q == HOLD_LAST) && (bit_q == BIT_LAST);

endmodule

// File: rtl/sram_host_sequencer.sv
// Host-side sequencer for the mixed-signal SRAM: serial word writes with
// row bursts, pulsed reads with timeout, one registered response port.
module sram_host_sequencer
  import sram_host_pkg::*;
#(
  parameter int ROWS       = 16,
  parameter int COLS       = 8,
  parameter int SHIFT_HOLD = 2,
  parameter int RD_TIMEOUT = 16,
  parameter int MAX_BURST  = 4,
  localparam int AW = calc_aw(ROWS),
  localparam int LW = calc_lw(MAX_BURST)
) (
  input  logic                 clk,
  input  logic                 arst_n,
  sram_host_sequencer_if.slave host,
  output logic                 busy,
  output logic                 sram_serial_in,
  output logic                 sram_shift,
  output logic                 sram_w_en,
  output logic                 sram_r_en,
  output logic [AW-1:0]        sram_addr,
  input  logic                 sram_data_valid,
  input  logic [COLS-1:0]      sram_data_out
);

  localparam int TW = cnt_w(RD_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(RD_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic [LW-1:0]   beats_q;
  logic [COLS-1:0] wdata_q;
  logic [TW-1:0]   wait_q;

  logic            accept;
  logic            last_beat;
  logic            timeout;
  logic            ser_load;
  logic            ser_done;
  logic            ser_bit;
  logic [COLS-1:0] ser_data;

  logic            req_ready_q, req_ready_d;
  logic            busy_q, busy_d;
  logic            shift_q, shift_d;
  logic            w_en_q, w_en_d;
  logic            r_en_q, r_en_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_error_q, rsp_error_d;
  logic            rsp_last_q, rsp_last_d;
  logic [COLS-1:0] rsp_rdata_q, rsp_rdata_d;

  assign accept    = (state_q == ST_IDLE) && host.req_valid;
  assign last_beat = (beats_q == '0);
  assign timeout   = (wait_q == TO_LAST);

  // The serializer is loaded on the same edge that enters SHIFT, so its
  // first bit is on the line in the first SHIFT cycle.
  assign ser_load = (state_d == ST_SHIFT) && (state_q != ST_SHIFT);
  assign ser_data = (state_q == ST_IDLE) ? host.req_wdata : wdata_q;

  sram_bit_serializer #(
    .COLS       (COLS),
    .SHIFT_HOLD (SHIFT_HOLD)
  ) u_ser (
    .clk        (clk),
    .arst_n     (arst_n),
    .load       (ser_load),
    .load_data  (ser_data),
    .serial_out (ser_bit),
    .done       (ser_done)
  );

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host.req_valid)
          state_d = (op_e'(host.req_write) == OP_WR) ? ST_SHIFT : ST_RSETUP;
      end
      ST_SHIFT:  if (ser_done) state_d = ST_WSETUP;
      ST_WSETUP: state_d = ST_WPULSE;
      ST_WPULSE: state_d = last_beat ? ST_RESP : ST_SHIFT;
      ST_RESP:   state_d = ST_IDLE;
      ST_RSETUP: state_d = ST_RPULSE;
      ST_RPULSE: state_d = ST_RWAIT;
      ST_RWAIT: begin
        if (sram_data_valid) state_d = last_beat ? ST_IDLE : ST_RSETUP;
        else if (timeout)    state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request latch, burst address/beat tracking and read wait counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_q  <= '0;
      beats_q <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= host.req_addr;
        beats_q <= host.req_len;
        wdata_q <= host.req_wdata;
      end else if (!last_beat &&
                   ((state_q == ST_WPULSE) ||
                    ((state_q == ST_RWAIT) && sram_data_valid))) begin
        addr_q  <= addr_q + 1'b1;
        beats_q <= beats_q - 1'b1;
      end
      if (state_q == ST_RWAIT) wait_q <= wait_q + 1'b1;
      else                     wait_q <= '0;
    end
  end

  // Output decode from the upcoming state, so the registered outputs line
  // up with the state they describe.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    shift_d     = (state_d == ST_SHIFT);
    w_en_d      = (state_d == ST_WPULSE);
    r_en_d      = (state_d == ST_RPULSE);
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_rdata_d = '0;
    if (state_d == ST_RESP) begin
      rsp_valid_d = 1'b1;
      rsp_last_d  = 1'b1;
    end
    if (state_q == ST_RWAIT) begin
      if (sram_data_valid) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = sram_data_out;
        rsp_last_d  = last_beat;
      end else if (timeout) begin
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b1;
        rsp_last_d  = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      shift_q     <= 1'b0;
      w_en_q      <= 1'b0;
      r_en_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      shift_q     <= shift_d;
      w_en_q      <= w_en_d;
      r_en_q      <= r_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_last_q  <= rsp_last_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign host.req_ready = req_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rsp_rdata_q;
  assign host.rsp_error = rsp_error_q;
  assign host.rsp_last  = rsp_last_q;
  assign busy           = busy_q;
  assign sram_shift     = shift_q;
  assign sram_w_en      = w_en_q;
  assign sram_r_en      = r_en_q;
  assign sram_addr      = addr_q;
  assign sram_serial_in = ser_bit;

endmodule
